uart_tx_arbiter: RTL

Packet-level round-robin arbiter that shares the single UART transmit AXI-Stream input (8-bit `s_data_*` of `uart_axis`) between several on-chip requesters (e.g. GCC-PHAT result dumper, status reporter, debug echo). It sits between the requesters and `uart_axis`. Once a requester is granted, it keeps the grant until its `tlast` beat is accepted, so packets never interleave on the wire. It optionally prefixes each packet with a source-ID header byte.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Packet-level round-robin arbiter sharing one 8-bit UART TX
//            AXI-Stream sink between NUM_REQ requesters. Build macro
//            UART_ARB_HEADER_EN prefixes each packet with {4'hA,1'b0,id}.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_req_tdata,
    input  logic [NUM_REQ-1:0]            s_req_tvalid,
    input  logic [NUM_REQ-1:0]            s_req_tlast,
    output logic [NUM_REQ-1:0]            s_req_tready,
    output logic [DATA_WIDTH-1:0]         m_data_tdata,
    output logic                          m_data_tvalid,
    input  logic                          m_data_tready,
    output logic                          busy,
    output logic [2:0]                    grant_id
);

    localparam logic [2:0] C_RST_GRANT = 3'(NUM_REQ - 1);

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [2:0]              grant_q, grant_d;
    logic [2:0]              w_arb_grant;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_sel_valid;
    logic                    w_sel_last;

    // Lowest rotated distance from (grant+1) wins, giving round-robin order.
    always_comb begin
        int v_best;
        int v_dist;
        v_best      = NUM_REQ;
        v_dist      = 0;
        w_arb_grant = grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_dist = (i + NUM_REQ - 1 - int'(grant_q)) % NUM_REQ;
            if (s_req_tvalid[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_arb_grant = 3'(i);
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                w_sel_data  = s_req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = s_req_tvalid[i];
                w_sel_last  = s_req_tlast[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            grant_q <= C_RST_GRANT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        m_data_tvalid = 1'b0;
        m_data_tdata  = '0;
        s_req_tready  = '0;
        busy          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|s_req_tvalid) begin
                    grant_d = w_arb_grant;
`ifdef UART_ARB_HEADER_EN
                    state_d = ST_HEADER;
`else
                    state_d = ST_STREAM;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            ST_HEADER: begin
                busy          = 1'b1;
                m_data_tvalid = 1'b1;
                m_data_tdata  = DATA_WIDTH'({4'hA, 1'b0, grant_q});
                if (m_data_tready) begin
                    state_d = ST_STREAM;
                end
            end
`endif
            ST_STREAM: begin
                // Pure pass-through; the grant is held across tvalid gaps.
                busy          = 1'b1;
                m_data_tvalid = w_sel_valid;
                m_data_tdata  = w_sel_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    s_req_tready[i] = (grant_q == 3'(i)) && m_data_tready;
                end
                if (w_sel_valid && w_sel_last && m_data_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id = grant_q;

endmodule
`default_nettype wire
